irq_ctl: RTL and testbench
==========================

Name: irq_ctl

Overview:
- Memory-mapped interrupt controller for the beta CPU.
- Latches rising edges on up to NSRC external interrupt sources, applies a software mask, and drives beta's single irq input.
- Sequences one interrupt at a time through assert, claim and complete phases; nesting is not supported.
- Sits on beta's data bus (memAddr, memWriteData, MemRead, MemWrite). Top-level read mux selects rdata when hit=1.

Parameters:
- NSRC, 8, number of interrupt sources (1..31).
- BASE, 32'hFFFF_0000, register block base address (16-byte aligned).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- src  input  NSRC  interrupt source levels, synchronous to clk
- memAddr  input  32  beta data address
- memWriteData  input  32  beta store data
- MemRead  input  1  beta load strobe
- MemWrite  input  1  beta store strobe
- rdata  output  32  register read data (combinational)
- hit  output  1  memAddr[31:4]==BASE[31:4] (combinational)
- irq  output  1  registered interrupt request to beta

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: pending=0, mask=0, src_prev=0, insvc_id=0, state=IDLE, irq=0.
- Register map, selected by memAddr[3:2] when hit=1:
  - 0 PENDING: read pending, zero-extended. Write is write-1-to-clear.
  - 1 MASK: read/write mask[NSRC-1:0]. Upper data bits are ignored.
  - 2 CLAIM: read only. Writes are ignored.
  - 3 COMPLETE: write only. Reads return 0.
- Bus timing:
  - rdata=0 whenever hit=0 or MemRead=0.
  - Reads return pre-edge state. A write takes effect at the clock edge.
  - MemRead and MemWrite both high: the write executes and the read returns pre-edge data.
- Edge detect:
  - Each cycle, src_prev<=src.
  - rise = src & ~src_prev.
  - pending <= (pending & ~clr) | rise.
  - Set wins over any clear (PENDING W1C or claim) in the same cycle.
- Arbitration:
  - active = pending & mask.
  - Winner = lowest set index of active (index 0 has highest priority).
- State machine, with irq registered and equal to (next_state==ASSERT):
  - IDLE: if |active, go to ASSERT.
  - ASSERT:
    - If a CLAIM read occurs, rdata={1'b1, 26'd0, winner[4:0]}, pending[winner] clears (unless a simultaneous rise), insvc_id<=winner, and the state goes to SERVICE.
    - Otherwise, if active==0 (mask or W1C removed it), go to IDLE.
  - SERVICE:
    - irq=0.
    - A COMPLETE write with memWriteData[4:0]==insvc_id goes to IDLE.
    - A mismatched id is ignored and the state stays SERVICE.
    - New edges keep latching into pending.
  - A CLAIM read in IDLE or SERVICE returns 0 (bit31=0) with no state change.
- Latency:
  - A src rise sampled at edge k sets pending at edge k and irq at edge k+1.
  - After COMPLETE at edge m with active!=0: IDLE at m, irq high at m+1.
- Width rules: ids are 5 bits; NSRC>31 is illegal. Bits above NSRC-1 read 0 and ignore writes.
- A level held high produces only one pending event; a new event requires a fall and then a rise.
- Reset asserted in any state returns all state to reset values at that edge. An in-flight claim or complete is discarded.

Test Plan:
- Reset sanity: assert reset 2 cycles, then idle with src=0 -> irq=0, PENDING=0, MASK=0, CLAIM read=0.
- Single interrupt:
  - Stimulus: MASK=0x01, then src[0] rises at edge k.
  - Response: PENDING=0x01 after k; irq=1 after k+1.
  - CLAIM read -> 0x8000_0000; irq=0 next cycle.
  - COMPLETE write 0 -> IDLE, irq stays 0.
- Priority:
  - Stimulus: MASK=0xFF, src[5] and src[2] rise together.
  - Response: first CLAIM -> 0x8000_0002; after COMPLETE 2, irq reasserts one cycle later and CLAIM -> 0x8000_0005.
- Masked and dropped:
  - Stimulus: MASK=0, src[3] rises.
  - Response: PENDING=0x08, irq=0. Write MASK=0x08 -> irq=1 within 2 cycles; write MASK=0 while in ASSERT -> irq=0 next cycle, PENDING still 0x08.
- Simultaneous and mismatch:
  - Stimulus: src[1] re-rises in the same cycle as the CLAIM of id 1.
  - Response: PENDING bit1 stays 1.
  - COMPLETE 4 while insvc_id=1 -> remains SERVICE, irq=0; COMPLETE 1 -> irq=1 next cycle.
- Reset mid-service: in SERVICE with PENDING=0x10, assert reset -> next cycle irq=0, PENDING=0, MASK=0, CLAIM read=0.

Source files
------------

// File: rtl/irq_ctl_if.sv
// -----------------------------------------------------------------------------
// irq_ctl_if
// Beta data-bus view of the interrupt controller register block.
//   memAddr      [31:0]  CPU -> controller  data address
//   memWriteData [31:0]  CPU -> controller  store data
//   MemRead              CPU -> controller  load strobe
//   MemWrite             CPU -> controller  store strobe
//   rdata        [31:0]  controller -> CPU  register read data (combinational)
//   hit                  controller -> CPU  address falls in the register block
// -----------------------------------------------------------------------------
interface irq_ctl_if;
    logic [31:0] memAddr;
    logic [31:0] memWriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] rdata;
    logic        hit;

    modport master (
        output memAddr, memWriteData, MemRead, MemWrite,
        input  rdata, hit
    );

    modport slave (
        input  memAddr, memWriteData, MemRead, MemWrite,
        output rdata, hit
    );
endinterface

// File: rtl/irq_ctl.sv
// -----------------------------------------------------------------------------
// irq_ctl
// Memory-mapped interrupt controller for the beta CPU. Rising edges on the
// src inputs are latched into PENDING, gated by MASK, and the lowest-numbered
// active source is presented to the CPU one at a time through an
// ASSERT -> SERVICE (claimed) -> IDLE (completed) sequence.
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset
//   src    interrupt source levels, synchronous to clk
//   bus    beta data bus (slave side): address/data/strobes in, rdata/hit out
//   irq    registered interrupt request to beta
// Register map (memAddr[3:2]): 0 PENDING (W1C), 1 MASK, 2 CLAIM (RO),
// 3 COMPLETE (WO).
// -----------------------------------------------------------------------------
module irq_ctl #(
    parameter int          NSRC = 8,
    parameter logic [31:0] BASE = 32'hFFFF_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    irq_ctl_if.slave        bus,
    output logic            irq
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ASSERT  = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    // Lowest set index of vec; only meaningful when vec is non-zero.
    function automatic logic [4:0] lowest_id(input logic [NSRC-1:0] vec);
        logic [4:0] id;
        id = 5'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                id = 5'(i);
            end
        end
        return id;
    endfunction

    // One-hot decode of a source id.
    function automatic logic [NSRC-1:0] id_to_bit(input logic [4:0] id);
        logic [NSRC-1:0] oh;
        for (int i = 0; i < NSRC; i++) begin
            oh[i] = (5'(i) == id);
        end
        return oh;
    endfunction

    state_t          state_q, state_d;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] src_prev_q, src_prev_d;
    logic [4:0]      insvc_id_q, insvc_id_d;
    logic            irq_q, irq_d;

    logic            hit_s;
    logic [1:0]      reg_sel_s;
    logic            rd_en_s;
    logic            wr_en_s;
    logic [NSRC-1:0] rise_s;
    logic [NSRC-1:0] active_s;
    logic [4:0]      winner_s;
    logic            claim_ok_s;
    logic            complete_ok_s;
    logic [NSRC-1:0] clr_w1c_s;
    logic [NSRC-1:0] clr_claim_s;
    logic [31:0]     rdata_s;
    logic            unused_s;

    assign hit_s     = (bus.memAddr[31:4] == BASE[31:4]);
    assign bus.hit   = hit_s;
    assign bus.rdata = rdata_s;
    assign irq       = irq_q;

    // Address bits [1:0] and high data bits carry no information here.
    assign unused_s  = ^{bus.memAddr[1:0], bus.memWriteData};

    // Bus decode, edge detect, arbitration and next values of the datapath flops.
    always_comb begin
        reg_sel_s     = bus.memAddr[3:2];
        rd_en_s       = hit_s & bus.MemRead;
        wr_en_s       = hit_s & bus.MemWrite;
        rise_s        = src & ~src_prev_q;
        active_s      = pending_q & mask_q;
        winner_s      = lowest_id(active_s);
        // A claim only succeeds while the request is up and something is still active.
        claim_ok_s    = rd_en_s && (reg_sel_s == 2'd2) && (state_q == S_ASSERT) && (|active_s);
        complete_ok_s = wr_en_s && (reg_sel_s == 2'd3) && (state_q == S_SERVICE)
                        && (bus.memWriteData[4:0] == insvc_id_q);
        clr_w1c_s     = (wr_en_s && (reg_sel_s == 2'd0)) ? bus.memWriteData[NSRC-1:0]
                                                         : {NSRC{1'b0}};
        clr_claim_s   = claim_ok_s ? id_to_bit(winner_s) : {NSRC{1'b0}};
        // OR-ing rise last lets a fresh edge win over any same-cycle clear.
        pending_d     = (pending_q & ~(clr_w1c_s | clr_claim_s)) | rise_s;
        src_prev_d    = src;
        mask_d        = (wr_en_s && (reg_sel_s == 2'd1)) ? bus.memWriteData[NSRC-1:0] : mask_q;
        insvc_id_d    = claim_ok_s ? winner_s : insvc_id_q;
    end

    // Next-state logic of the assert/claim/complete sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (|active_s) begin
                    state_d = S_ASSERT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ASSERT: begin
                if (claim_ok_s) begin
                    state_d = S_SERVICE;
                end else if (!(|active_s)) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ASSERT;
                end
            end
            S_SERVICE: begin
                if (complete_ok_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_SERVICE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs: irq flop input and the combinational register read mux.
    always_comb begin
        irq_d   = (state_d == S_ASSERT);
        rdata_s = 32'd0;
        if (rd_en_s) begin
            case (reg_sel_s)
                2'd0:    rdata_s = {{(32-NSRC){1'b0}}, pending_q};
                2'd1:    rdata_s = {{(32-NSRC){1'b0}}, mask_q};
                2'd2:    rdata_s = claim_ok_s ? {1'b1, 26'd0, winner_s} : 32'd0;
                2'd3:    rdata_s = 32'd0;
                default: rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and irq registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q  <= {NSRC{1'b0}};
            mask_q     <= {NSRC{1'b0}};
            src_prev_q <= {NSRC{1'b0}};
            insvc_id_q <= 5'd0;
            irq_q      <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            src_prev_q <= src_prev_d;
            insvc_id_q <= insvc_id_d;
            irq_q      <= irq_d;
        end
    end

endmodule

// File: tb/tb_irq_ctl.sv
// -----------------------------------------------------------------------------
// tb_irq_ctl
// Self-checking bench for irq_ctl: directed scenario tasks with fixed expected
// values, followed by randomized bus/source traffic checked against a
// behavioural model of pending/mask/claim/complete kept as plain integers.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_irq_ctl;
    localparam int          NSRC  = 8;
    localparam logic [31:0] BASE  = 32'hFFFF_0000;
    localparam int unsigned PMASK = (32'd1 << NSRC) - 32'd1;

    logic            clk = 1'b0;
    logic            reset;
    logic [NSRC-1:0] src;
    logic            irq;
    logic [31:0]     mem_addr;
    logic [31:0]     mem_wdata;
    logic            mem_rd;
    logic            mem_wr;

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model state.
    int unsigned m_pend  = 0;
    int unsigned m_mask  = 0;
    int unsigned m_prev  = 0;
    int unsigned m_insvc = 0;
    bit          m_irq   = 1'b0;
    bit          m_busy  = 1'b0;

    irq_ctl_if bus();
    assign bus.memAddr      = mem_addr;
    assign bus.memWriteData = mem_wdata;
    assign bus.MemRead      = mem_rd;
    assign bus.MemWrite     = mem_wr;

    irq_ctl #(.NSRC(NSRC), .BASE(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .src   (src),
        .bus   (bus.slave),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    function automatic int unsigned m_winner(input int unsigned act);
        return $clog2(act & (~act + 32'd1));
    endfunction

    function automatic bit m_hit();
        return (mem_addr >> 4) == (BASE >> 4);
    endfunction

    function automatic logic [31:0] m_rdata();
        int unsigned act;
        int unsigned sel;
        act = m_pend & m_mask;
        sel = (mem_addr >> 2) & 32'd3;
        if (!(m_hit() && mem_rd)) return 32'd0;
        case (sel)
            0: return m_pend;
            1: return m_mask;
            2: return (m_irq && act != 0) ? (32'h8000_0000 | m_winner(act)) : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Advance one clock; the model evaluates its next state from pre-edge inputs.
    task automatic tick();
        int unsigned act, rise, clr, sel, s, n_pend, n_mask, n_insvc;
        bit rd, wr, claim, n_irq, n_busy;
        s     = 32'(src);
        act   = m_pend & m_mask;
        rise  = s & ~m_prev;
        rd    = m_hit() && mem_rd;
        wr    = m_hit() && mem_wr;
        sel   = (mem_addr >> 2) & 32'd3;
        claim = rd && sel == 2 && m_irq && act != 0;
        clr   = 0;
        if (wr && sel == 0) clr = clr | (mem_wdata & PMASK);
        if (claim) clr = clr | (32'd1 << m_winner(act));
        n_pend  = ((m_pend & ~clr) | rise) & PMASK;
        n_mask  = (wr && sel == 1) ? (mem_wdata & PMASK) : m_mask;
        n_insvc = claim ? m_winner(act) : m_insvc;
        if (m_busy) begin
            n_irq  = 1'b0;
            n_busy = !(wr && sel == 3 && (mem_wdata & 32'd31) == m_insvc);
        end else if (m_irq) begin
            n_busy = claim;
            n_irq  = !claim && act != 0;
        end else begin
            n_busy = 1'b0;
            n_irq  = act != 0;
        end
        @(posedge clk);
        if (reset) begin
            m_pend = 0; m_mask = 0; m_prev = 0; m_insvc = 0; m_irq = 0; m_busy = 0;
        end else begin
            m_pend = n_pend; m_mask = n_mask; m_prev = s; m_insvc = n_insvc;
            m_irq = n_irq; m_busy = n_busy;
        end
        #1;
    endtask

    task automatic drive_none();
        mem_addr = 32'd0; mem_wdata = 32'd0; mem_rd = 1'b0; mem_wr = 1'b0;
    endtask

    task automatic drive_rd(input logic [1:0] sel);
        mem_addr = BASE | {28'd0, sel, 2'b00}; mem_wdata = 32'd0; mem_rd = 1'b1; mem_wr = 1'b0;
    endtask

    task automatic drive_wr(input logic [1:0] sel, input logic [31:0] data);
        mem_addr = BASE | {28'd0, sel, 2'b00}; mem_wdata = data; mem_rd = 1'b0; mem_wr = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; src = '0; drive_none();
        tick(); tick();
        reset = 1'b0;
        tick();
        tests_run++;
        if (irq !== 1'b0) begin tests_failed++; $display("FAIL reset_irq: got %b want 0", irq); end
        drive_rd(2'd0); #1;
        tests_run++;
        if (bus.rdata !== 32'd0) begin tests_failed++; $display("FAIL reset_pending: got %h want 0", bus.rdata); end
        tests_run++;
        if (bus.hit !== 1'b1) begin tests_failed++; $display("FAIL reset_hit: got %b want 1", bus.hit); end
        tick();
        drive_rd(2'd1); #1;
        tests_run++;
        if (bus.rdata !== 32'd0) begin tests_failed++; $display("FAIL reset_mask: got %h want 0", bus.rdata); end
        tick();
        drive_rd(2'd2); #1;
        tests_run++;
        if (bus.rdata !== 32'd0) begin tests_failed++; $display("FAIL reset_claim: got %h want 0", bus.rdata); end
        tick();
        mem_addr = 32'h1234_0008; mem_rd = 1'b1; #1;
        tests_run++;
        if (bus.hit !== 1'b0 || bus.rdata !== 32'd0) begin
            tests_failed++; $display("FAIL miss_read: hit %b rdata %h want 0 0", bus.hit, bus.rdata);
        end
        tick();
        drive_none();
    endtask

    task automatic test_single();
        drive_wr(2'd1, 32'h0000_0001); tick();
        drive_none(); src = 8'h01; tick();
        drive_rd(2'd0); #1;
        tests_run++;
        if (bus.rdata !== 32'h1) begin tests_failed++; $display("FAIL single_pending: got %h want 1", bus.rdata); end
        tests_run++;
        if (irq !== 1'b0) begin tests_failed++; $display("FAIL single_irq_k: got %b want 0", irq); end
        tick();
        tests_run++;
        if (irq !== 1'b1) begin tests_failed++; $display("FAIL single_irq_k1: got %b want 1", irq); end
        drive_rd(2'd2); #1;
        tests_run++;
        if (bus.rdata !== 32'h8000_0000) begin tests_failed++; $display("FAIL single_claim: got %h want 80000000", bus.rdata); end
        tick();
        tests_run++;
        if (irq !== 1'b0) begin tests_failed++; $display("FAIL single_irq_claimed: got %b want 0", irq); end
        drive_wr(2'd3, 32'd0); tick();
        drive_rd(2'd0); #1;
        tests_run++;
        if (bus.rdata !== 32'd0) begin tests_failed++; $display("FAIL single_pending_clr: got %h want 0", bus.rdata); end
        tick();
        tests_run++;
        if (irq !== 1'b0) begin tests_failed++; $display("FAIL single_irq_done: got %b want 0", irq); end
        src = 8'h00; drive_none(); tick();
    endtask

    task automatic test_priority();
        drive_wr(2'd1, 32'h0000_00FF); src = 8'h24; tick();
        drive_none(); tick();
        tests_run++;
        if (irq !== 1'b1) begin tests_failed++; $display("FAIL prio_irq: got %b want 1", irq); end
        drive_rd(2'd2); #1;
        tests_run++;
        if (bus.rdata !== 32'h8000_0002) begin tests_failed++; $display("FAIL prio_claim1: got %h want 80000002", bus.rdata); end
        tick();
        drive_wr(2'd3, 32'd2); tick();
        tests_run++;
        if (irq !== 1'b0) begin tests_failed++; $display("FAIL prio_irq_m: got %b want 0", irq); end
        drive_none(); tick();
        tests_run++;
        if (irq !== 1'b1) begin tests_failed++; $display("FAIL prio_irq_m1: got %b want 1", irq); end
        drive_rd(2'd2); #1;
        tests_run++;
        if (bus.rdata !== 32'h8000_0005) begin tests_failed++; $display("FAIL prio_claim2: got %h want 80000005", bus.rdata); end
        tick();
        drive_wr(2'd3, 32'd5); tick();
        drive_none(); src = 8'h00; tick();
        tests_run++;
        if (irq !== 1'b0) begin tests_failed++; $display("FAIL prio_done: got %b want 0", irq); end
    endtask

    task automatic test_masked();
        drive_wr(2'd1, 32'd0); src = 8'h08; tick();
        drive_rd(2'd0); #1;
        tests_run++;
        if (bus.rdata !== 32'h08 || irq !== 1'b0) begin
            tests_failed++; $display("FAIL masked_pending: rdata %h irq %b want 08 0", bus.rdata, irq);
        end
        tick();
        drive_wr(2'd1, 32'h0000_0008); tick();
        drive_none(); tick();
        tests_run++;
        if (irq !== 1'b1) begin tests_failed++; $display("FAIL masked_unmask: got %b want 1", irq); end
        drive_wr(2'd1, 32'd0); tick();
        drive_none(); tick();
        tests_run++;
        if (irq !== 1'b0) begin tests_failed++; $display("FAIL masked_drop: got %b want 0", irq); end
        drive_rd(2'd0); #1;
        tests_run++;
        if (bus.rdata !== 32'h08) begin tests_failed++; $display("FAIL masked_still_pending: got %h want 08", bus.rdata); end
        tick();
        drive_wr(2'd0, 32'h0000_0008); tick();
        src = 8'h00; drive_rd(2'd0); #1;
        tests_run++;
        if (bus.rdata !== 32'd0) begin tests_failed++; $display("FAIL masked_w1c: got %h want 0", bus.rdata); end
        tick();
        drive_none();
    endtask

    task automatic test_simul_mismatch();
        drive_wr(2'd1, 32'h0000_00FF); tick();
        drive_none(); src = 8'h02; tick();
        src = 8'h00; tick();
        tests_run++;
        if (irq !== 1'b1) begin tests_failed++; $display("FAIL simul_irq: got %b want 1", irq); end
        drive_rd(2'd2); src = 8'h02; #1;
        tests_run++;
        if (bus.rdata !== 32'h8000_0001) begin tests_failed++; $display("FAIL simul_claim: got %h want 80000001", bus.rdata); end
        tick();
        drive_rd(2'd0); #1;
        tests_run++;
        if (bus.rdata !== 32'h02 || irq !== 1'b0) begin
            tests_failed++; $display("FAIL simul_set_wins: rdata %h irq %b want 02 0", bus.rdata, irq);
        end
        tick();
        drive_wr(2'd3, 32'd4); tick();
        tests_run++;
        if (irq !== 1'b0) begin tests_failed++; $display("FAIL mismatch_irq: got %b want 0", irq); end
        drive_rd(2'd2); #1;
        tests_run++;
        if (bus.rdata !== 32'd0) begin tests_failed++; $display("FAIL mismatch_claim: got %h want 0", bus.rdata); end
        tick();
        drive_wr(2'd3, 32'd1); tick();
        drive_none(); tick();
        tests_run++;
        if (irq !== 1'b1) begin tests_failed++; $display("FAIL match_reassert: got %b want 1", irq); end
        drive_rd(2'd2); #1;
        tests_run++;
        if (bus.rdata !== 32'h8000_0001) begin tests_failed++; $display("FAIL simul_reclaim: got %h want 80000001", bus.rdata); end
        tick();
        drive_wr(2'd3, 32'd1); tick();
        src = 8'h00; drive_none(); tick();
    endtask

    task automatic test_reset_mid();
        drive_wr(2'd1, 32'h0000_0010); src = 8'h10; tick();
        drive_none(); tick();
        drive_rd(2'd2); #1;
        tests_run++;
        if (bus.rdata !== 32'h8000_0004) begin tests_failed++; $display("FAIL rmid_claim: got %h want 80000004", bus.rdata); end
        tick();
        src = 8'h00; drive_none(); tick();
        src = 8'h10; tick();
        drive_rd(2'd0); #1;
        tests_run++;
        if (bus.rdata !== 32'h10 || irq !== 1'b0) begin
            tests_failed++; $display("FAIL rmid_service: rdata %h irq %b want 10 0", bus.rdata, irq);
        end
        reset = 1'b1; src = 8'h00; drive_none(); tick();
        reset = 1'b0;
        tests_run++;
        if (irq !== 1'b0) begin tests_failed++; $display("FAIL rmid_irq: got %b want 0", irq); end
        drive_rd(2'd0); #1;
        tests_run++;
        if (bus.rdata !== 32'd0) begin tests_failed++; $display("FAIL rmid_pending: got %h want 0", bus.rdata); end
        tick();
        drive_rd(2'd1); #1;
        tests_run++;
        if (bus.rdata !== 32'd0) begin tests_failed++; $display("FAIL rmid_mask: got %h want 0", bus.rdata); end
        tick();
        drive_rd(2'd2); #1;
        tests_run++;
        if (bus.rdata !== 32'd0) begin tests_failed++; $display("FAIL rmid_claim0: got %h want 0", bus.rdata); end
        tick();
        drive_none();
    endtask

    task automatic test_random();
        int unsigned op, sel, data;
        logic [NSRC-1:0] flip;
        logic [31:0] exp_rd;
        for (int c = 0; c < 3000; c++) begin
            flip  = NSRC'($urandom & $urandom & $urandom);
            src   = src ^ flip;
            reset = ($urandom_range(0, 299) == 0);
            op    = $urandom_range(0, 7);
            sel   = $urandom_range(0, 3);
            data  = $urandom;
            if (sel == 3 && $urandom_range(0, 1) == 1) data = m_insvc;
            if ($urandom_range(0, 9) == 0) mem_addr = $urandom;
            else mem_addr = BASE | (sel << 2) | $urandom_range(0, 3);
            mem_wdata = data;
            mem_rd    = (op == 3 || op == 4 || op == 7);
            mem_wr    = (op == 5 || op == 6 || op == 7);
            #1;
            exp_rd = m_rdata();
            tests_run++;
            if (bus.rdata !== exp_rd || bus.hit !== m_hit()) begin
                tests_failed++;
                $display("FAIL rand_read c=%0d: rdata %h hit %b want %h %b", c, bus.rdata, bus.hit, exp_rd, m_hit());
            end
            tick();
            tests_run++;
            if (irq !== m_irq) begin
                tests_failed++; $display("FAIL rand_irq c=%0d: got %b want %b", c, irq, m_irq);
            end
        end
        reset = 1'b0; drive_none();
    endtask

    initial begin
        reset = 1'b1; src = '0; drive_none();
        test_reset();
        test_single();
        test_priority();
        test_masked();
        test_simul_mismatch();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
